// File: rtl/mux_srcdata_pipe_if.sv
// mux_srcdata_pipe_if: source-select handshake bundle.
// Upstream beat in (data_in/sel/in_valid/in_ready), selected beat out.
interface mux_srcdata_pipe_if #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 9,
   parameter int SEL_W  = 4
);
   logic [NUM_IN*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]        sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output data_in, sel, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_err, out_valid
   );

   modport slave (
      input  data_in, sel, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_err, out_valid
   );
endinterface

// File: rtl/mux_srcdata_pipe.sv
// mux_srcdata_pipe: registered N-input source-data selector with
// output + skid buffer, out-of-range flagging and a beat counter.
module mux_srcdata_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 9,
   parameter int SEL_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   mux_srcdata_pipe_if.slave bus,
   input  logic              clr_err,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  beat_cnt
);
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             err;
   } beat_t;

   beat_t nb;
   beat_t out_q;
   beat_t skid_q;
   logic  out_v;
   logic  skid_v;
   logic  acc;
   logic  pop;

   assign acc = bus.in_valid & ~skid_v;
   assign pop = out_v & bus.out_ready;

   assign bus.in_ready  = ~skid_v;
   assign bus.out_valid = out_v;
   assign bus.out_data  = out_q.data;
   assign bus.out_sel   = out_q.sel;
   assign bus.out_err   = out_q.err;

   // Decode select; unmatched selects fall through to the last channel.
   always_comb begin
      nb.data = bus.data_in[(NUM_IN-1)*WIDTH +: WIDTH];
      nb.sel  = bus.sel;
      nb.err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.sel == SEL_W'(k)) begin
            nb.data = bus.data_in[k*WIDTH +: WIDTH];
            nb.err  = 1'b0;
         end
      end
   end

   // Two-entry elastic buffer: skid drains first to keep FIFO order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q  <= '0;
         out_v  <= 1'b0;
         skid_q <= '0;
         skid_v <= 1'b0;
      end else if (!out_v || pop) begin
         if (skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= 1'b0;
         end else if (acc) begin
            out_q <= nb;
            out_v <= 1'b1;
         end else begin
            out_v <= 1'b0;
         end
      end else if (acc) begin
         skid_q <= nb;
         skid_v <= 1'b1;
      end
   end

   // Sticky error: a new bad beat outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_sticky <= 1'b0;
      end else if (acc && nb.err) begin
         err_sticky <= 1'b1;
      end else if (clr_err) begin
         err_sticky <= 1'b0;
      end
   end

   // Count accepted beats, wrapping at the counter width.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
      end else if (acc) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end
endmodule
